// File: rtl/car_lights_pkg.sv
// Shared definitions for the car light switch path: exterior select codes,
// the default debounce length and the select priority function.
package car_lights_pkg;

  typedef enum logic [1:0] {
    SEL_OFF       = 2'b00,
    SEL_LEFT      = 2'b01,
    SEL_RIGHT     = 2'b10,
    SEL_BREAKDOWN = 2'b11
  } sel_e;

  localparam int unsigned DEBOUNCE_DEFAULT = 32'd4;

  // Breakdown latch overrides the key; a single stalk direction is needed for a turn.
  function automatic sel_e select_code(input logic latch, input logic key,
                                       input logic left, input logic right);
    sel_e code;
    if (latch) begin
      code = SEL_BREAKDOWN;
    end else if (!key) begin
      code = SEL_OFF;
    end else if (left && !right) begin
      code = SEL_LEFT;
    end else if (right && !left) begin
      code = SEL_RIGHT;
    end else begin
      code = SEL_OFF;
    end
    return code;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Single-bit switch debouncer: the stable value follows the input only after
// DEBOUNCE_CYCLES consecutive samples that disagree with it.
module switch_debounce
  import car_lights_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  // The >= compare doubles as saturation so the counter can never wrap.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (raw_i == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      stable_d = raw_i;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/car_switch_conditioner.sv
// Debounces door/key/stalk/hazard contacts and derives the exterior light code.
// Optional SWITCH_SYNC_EN inserts a 2-flop synchroniser ahead of every debouncer.
module car_switch_conditioner
  import car_lights_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] raw_door,
  input  logic       raw_key,
  input  logic       raw_left,
  input  logic       raw_right,
  input  logic       raw_hazard,
  output logic [3:0] door,
  output logic       key,
  output logic [1:0] select_ext,
  output logic       changed
);

  // Bit map: [3:0] doors, [4] key, [5] left, [6] right, [7] hazard.
  logic [7:0] raw_s;
  logic [7:0] deb_in_s;
  logic [7:0] deb_s;

  assign raw_s = {raw_hazard, raw_right, raw_left, raw_key, raw_door};

`ifdef SWITCH_SYNC_EN
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign deb_in_s = sync2_q;
`else
  assign deb_in_s = raw_s;
`endif

  for (genvar i = 0; i < 8; i++) begin : g_deb
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (deb_in_s[i]),
      .stable_o(deb_s[i])
    );
  end

  logic       haz_prev_q, haz_prev_d;
  logic       latch_q, latch_d;
  logic [1:0] sel_q, sel_d;
  logic [6:0] snap_q, snap_d;
  logic       changed_q, changed_d;

  // The select code uses the post-toggle latch so a same-cycle hazard edge wins.
  always_comb begin
    haz_prev_d = deb_s[7];
    latch_d    = latch_q ^ (deb_s[7] & ~haz_prev_q);
    sel_d      = select_code(latch_d, deb_s[4], deb_s[5], deb_s[6]);
    snap_d     = {deb_s[4:0], sel_q};
    changed_d  = (snap_d != snap_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      haz_prev_q <= 1'b0;
      latch_q    <= 1'b0;
      sel_q      <= 2'b00;
      snap_q     <= 7'h00;
      changed_q  <= 1'b0;
    end else begin
      haz_prev_q <= haz_prev_d;
      latch_q    <= latch_d;
      sel_q      <= sel_d;
      snap_q     <= snap_d;
      changed_q  <= changed_d;
    end
  end

  assign door       = deb_s[3:0];
  assign key        = deb_s[4];
  assign select_ext = sel_q;
  assign changed    = changed_q;

endmodule

// File: tb/tb_car_switch_conditioner.sv
// Scoreboard bench for car_switch_conditioner: expectations are queued with the
// cycle they are due when stimulus is driven and compared on the falling edge.
module tb_car_switch_conditioner;

`ifdef SWITCH_SYNC_EN
  localparam int D = 6;
`else
  localparam int D = 4;
`endif

  localparam logic [7:0] M_DOOR = 8'hF0;
  localparam logic [7:0] M_KEY  = 8'h08;
  localparam logic [7:0] M_SEL  = 8'h06;
  localparam logic [7:0] M_CHG  = 8'h01;
  localparam logic [7:0] M_ALL  = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_door;
  logic       raw_key, raw_left, raw_right, raw_hazard;
  logic [3:0] door;
  logic       key;
  logic [1:0] select_ext;
  logic       changed;
  logic [7:0] obs;

  typedef struct {
    int         cyc;
    logic [7:0] exp;
    logic [7:0] mask;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  car_switch_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_door  (raw_door),
    .raw_key   (raw_key),
    .raw_left  (raw_left),
    .raw_right (raw_right),
    .raw_hazard(raw_hazard),
    .door      (door),
    .key       (key),
    .select_ext(select_ext),
    .changed   (changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign obs = {door, key, select_ext, changed};

  function automatic logic [7:0] pk(input logic [3:0] d, input logic k, input logic [1:0] s, input logic c);
    return {d, k, s, c};
  endfunction

  function automatic void expect_at(input int c, input logic [7:0] e, input logic [7:0] m, input string n);
    exp_t x;
    x.cyc = c; x.exp = e; x.mask = m; x.name = n;
    sb.push_back(x);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    raw_door = 4'hF; raw_key = 1'b1; raw_left = 1'b1; raw_right = 1'b1; raw_hazard = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL reset_hold got=%b want=%b", obs, 8'h00);
    end
    raw_door = 4'h0; raw_key = 1'b0; raw_left = 1'b0; raw_right = 1'b0; raw_hazard = 1'b0;
    rst_n = 1'b1;
    for (int t = 0; t < D + 6; t++) begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          total++;
          if ((obs & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", sb[i].name, cyc, obs, sb[i].exp, sb[i].mask);
          end
          sb.delete(i);
        end
      end
      if (t == 1) begin
        raw_door = 4'b0100;
        expect_at(cyc + D - 1, pk(4'b0000, 1'b0, 2'b00, 1'b0), M_DOOR, "door_early");
        expect_at(cyc + D,     pk(4'b0100, 1'b0, 2'b00, 1'b0), M_DOOR | M_CHG, "door_set");
        expect_at(cyc + D + 1, pk(4'b0100, 1'b0, 2'b00, 1'b1), M_ALL, "chg_pulse");
        expect_at(cyc + D + 2, pk(4'b0100, 1'b0, 2'b00, 1'b0), M_ALL, "chg_drop");
      end
    end
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 2 * D + 9; t++) begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          total++;
          if ((obs & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", sb[i].name, cyc, obs, sb[i].exp, sb[i].mask);
          end
          sb.delete(i);
        end
      end
      if (t <= 4) raw_key = (t % 2 == 0);
      if (t == 0) begin
        for (int j = 1; j <= D + 3; j++) expect_at(cyc + j, 8'h00, M_KEY, "key_bounce");
      end
      if (t == 4) begin
        expect_at(cyc + D,     pk(4'b0100, 1'b1, 2'b00, 1'b0), M_KEY, "key_settle");
        expect_at(cyc + D + 1, pk(4'b0100, 1'b1, 2'b00, 1'b1), M_ALL, "key_chg");
      end
      if (t == D + 6) begin
        raw_key = 1'b0;
        expect_at(cyc + D - 1, pk(4'b0000, 1'b1, 2'b00, 1'b0), M_KEY, "key_hold");
        expect_at(cyc + D,     pk(4'b0000, 1'b0, 2'b00, 1'b0), M_KEY, "key_off");
      end
    end
  endtask

  task automatic test_gating();
    for (int t = 0; t < 4 * D + 10; t++) begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          total++;
          if ((obs & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", sb[i].name, cyc, obs, sb[i].exp, sb[i].mask);
          end
          sb.delete(i);
        end
      end
      if (t == 0) begin
        raw_left = 1'b1;
        expect_at(cyc + D + 1, pk(4'b0000, 1'b0, 2'b00, 1'b0), M_SEL, "left_no_key");
        expect_at(cyc + D + 2, pk(4'b0000, 1'b0, 2'b00, 1'b0), M_SEL, "left_no_key2");
      end
      if (t == D + 3) begin
        raw_key = 1'b1;
        expect_at(cyc + D - 1, pk(4'b0000, 1'b0, 2'b00, 1'b0), M_KEY | M_SEL, "gate_pre");
        expect_at(cyc + D,     pk(4'b0000, 1'b1, 2'b00, 1'b0), M_KEY | M_SEL, "gate_key");
        expect_at(cyc + D + 1, pk(4'b0000, 1'b1, 2'b01, 1'b1), M_KEY | M_SEL | M_CHG, "gate_left");
      end
      if (t == 2 * D + 5) begin
        raw_right = 1'b1;
        expect_at(cyc + D,     pk(4'b0000, 1'b1, 2'b01, 1'b0), M_SEL, "both_pre");
        expect_at(cyc + D + 1, pk(4'b0000, 1'b1, 2'b00, 1'b0), M_SEL, "both_off");
        expect_at(cyc + D + 3, pk(4'b0000, 1'b1, 2'b00, 1'b0), M_SEL, "both_off2");
      end
      if (t == 3 * D + 8) begin
        raw_left = 1'b0;
        raw_right = 1'b0;
      end
    end
  endtask

  task automatic test_hazard();
    for (int t = 0; t < 5 * D + 34; t++) begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          total++;
          if ((obs & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", sb[i].name, cyc, obs, sb[i].exp, sb[i].mask);
          end
          sb.delete(i);
        end
      end
      case (t)
        0: raw_key = 1'b0;
        D + 3: begin
          raw_hazard = 1'b1;
          expect_at(cyc + D,     pk(4'b0000, 1'b0, 2'b00, 1'b0), M_SEL, "haz_pre");
          expect_at(cyc + D + 1, pk(4'b0000, 1'b0, 2'b11, 1'b0), M_SEL, "haz_on");
          expect_at(cyc + D + 2, pk(4'b0000, 1'b0, 2'b11, 1'b0), M_SEL, "haz_hold");
        end
        D + 9: begin
          raw_hazard = 1'b0;
          expect_at(cyc + D + 3, pk(4'b0000, 1'b0, 2'b11, 1'b0), M_SEL, "haz_one_toggle");
        end
        2 * D + 13: begin
          raw_key = 1'b1;
          raw_left = 1'b1;
          expect_at(cyc + D + 2, pk(4'b0000, 1'b1, 2'b11, 1'b0), M_KEY | M_SEL, "haz_over_left");
        end
        3 * D + 16: begin
          raw_hazard = 1'b1;
          expect_at(cyc + D,     pk(4'b0000, 1'b1, 2'b11, 1'b0), M_SEL, "haz2_pre");
          expect_at(cyc + D + 1, pk(4'b0000, 1'b1, 2'b01, 1'b0), M_SEL, "haz2_off");
        end
        3 * D + 22: begin
          raw_hazard = 1'b0;
          expect_at(cyc + D + 3, pk(4'b0000, 1'b1, 2'b01, 1'b0), M_SEL, "haz2_release");
        end
        4 * D + 25: begin
          raw_hazard = 1'b1;
          expect_at(cyc + D + 1, pk(4'b0000, 1'b1, 2'b11, 1'b0), M_SEL, "haz3_on");
        end
        4 * D + 31: raw_hazard = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_midop_reset();
    raw_door = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL midop_reset_now got=%b want=%b", obs, 8'h00);
    end
    repeat (2) @(negedge clk);
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL midop_reset_hold got=%b want=%b", obs, 8'h00);
    end
    for (int t = 0; t < D + 3; t++) begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          total++;
          if ((obs & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", sb[i].name, cyc, obs, sb[i].exp, sb[i].mask);
          end
          sb.delete(i);
        end
      end
      if (t == 0) begin
        rst_n = 1'b1;
        for (int j = 1; j < D; j++) expect_at(cyc + j, 8'h00, M_ALL, "requal_wait");
        expect_at(cyc + D,     pk(4'b0000, 1'b1, 2'b00, 1'b0), M_ALL, "requal_key");
        expect_at(cyc + D + 1, pk(4'b0000, 1'b1, 2'b01, 1'b1), M_ALL, "requal_sel");
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_gating();
    test_hazard();
    test_midop_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
